// File: rtl/decade_step_monitor.sv
// decade_step_monitor: tracks a one-hot decade counter (Q0..Q9), encodes the
// active step to BCD, emits step/carry/restart pulses, counts completed
// decades and latches the first illegal-pattern fault until cleared.
module decade_step_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       q_in,
    input  logic             clr,
    output logic [3:0]       digit,
    output logic             locked,
    output logic             step_pulse,
    output logic             carry_pulse,
    output logic             restart_pulse,
    output logic [CNT_W-1:0] decade_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_SKIP  = 2'b01;
    localparam logic [1:0] CODE_ZERO  = 2'b10;
    localparam logic [1:0] CODE_MULTI = 2'b11;

    state_t             state, state_n;
    logic [3:0]         digit_n;
    logic               locked_n;
    logic               step_n, carry_n, restart_n;
    logic [CNT_W-1:0]   count_n;
    logic               err_n;
    logic [1:0]         code_n;

    logic [3:0]         hot_cnt;
    logic [3:0]         hot_idx;
    logic [3:0]         next_step;
    logic               is_zero, is_one;

    // Classify the sampled vector: number of hot bits and position of the hot bit
    always_comb begin
        hot_cnt = 4'd0;
        hot_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (q_in[i]) begin
                hot_cnt = hot_cnt + 4'd1;
                hot_idx = 4'(i);
            end
        end
        is_zero   = (hot_cnt == 4'd0);
        is_one    = (hot_cnt == 4'd1);
        next_step = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end

    // Next-state and next-output decode
    always_comb begin
        state_n   = state;
        digit_n   = digit;
        locked_n  = locked;
        step_n    = 1'b0;
        carry_n   = 1'b0;
        restart_n = 1'b0;
        count_n   = decade_count;
        err_n     = err;
        code_n    = err_code;

        if (clr) begin
            // Clear wins over whatever q_in carries this cycle
            state_n  = SYNC;
            digit_n  = 4'd0;
            locked_n = 1'b0;
            count_n  = '0;
            err_n    = 1'b0;
            code_n   = CODE_NONE;
        end else begin
            case (state)
                SYNC: begin
                    if (is_one) begin
                        state_n  = TRACK;
                        digit_n  = hot_idx;
                        locked_n = 1'b1;
                    end else if (!is_zero) begin
                        state_n  = FAULT;
                        locked_n = 1'b0;
                        err_n    = 1'b1;
                        code_n   = CODE_MULTI;
                    end
                end
                TRACK: begin
                    if (is_zero) begin
                        state_n  = FAULT;
                        locked_n = 1'b0;
                        err_n    = 1'b1;
                        code_n   = CODE_ZERO;
                    end else if (!is_one) begin
                        state_n  = FAULT;
                        locked_n = 1'b0;
                        err_n    = 1'b1;
                        code_n   = CODE_MULTI;
                    end else if (hot_idx == digit) begin
                        // Counter disabled: hold without pulses
                        state_n = TRACK;
                    end else if (hot_idx == next_step) begin
                        digit_n = hot_idx;
                        step_n  = 1'b1;
                        if (digit == 4'd9) begin
                            carry_n = 1'b1;
                            count_n = decade_count + CNT_W'(1);
                        end
                    end else if (hot_idx == 4'd0) begin
                        // Counter's own reset back to Q0
                        digit_n   = 4'd0;
                        restart_n = 1'b1;
                    end else begin
                        state_n  = FAULT;
                        locked_n = 1'b0;
                        err_n    = 1'b1;
                        code_n   = CODE_SKIP;
                    end
                end
                FAULT: begin
                    // Sticky: first cause kept, everything frozen until clr
                    locked_n = 1'b0;
                    err_n    = 1'b1;
                end
                default: begin
                    state_n  = SYNC;
                    digit_n  = 4'd0;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SYNC;
            digit         <= 4'd0;
            locked        <= 1'b0;
            step_pulse    <= 1'b0;
            carry_pulse   <= 1'b0;
            restart_pulse <= 1'b0;
            decade_count  <= '0;
            err           <= 1'b0;
            err_code      <= CODE_NONE;
        end else begin
            state         <= state_n;
            digit         <= digit_n;
            locked        <= locked_n;
            step_pulse    <= step_n;
            carry_pulse   <= carry_n;
            restart_pulse <= restart_n;
            decade_count  <= count_n;
            err           <= err_n;
            err_code      <= code_n;
        end
    end

endmodule

// File: tb/tb_decade_step_monitor.sv
// Scoreboard bench for decade_step_monitor: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; expected outputs are queued per driven cycle and popped after the edge.
module tb_decade_step_monitor;

    typedef struct packed {
        logic [3:0] digit;
        logic       locked;
        logic       step;
        logic       carry;
        logic       restart;
        logic [7:0] c8;
        logic [1:0] c2;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] q_in;
    logic       clr;

    logic [3:0] digit_a, digit_b;
    logic       locked_a, locked_b;
    logic       step_a, step_b, carry_a, carry_b, restart_a, restart_b;
    logic [7:0] count_a;
    logic [1:0] count_b;
    logic       err_a, err_b;
    logic [1:0] code_a, code_b;

    exp_t obs_a, obs_b;
    exp_t sb[$];
    exp_t e;
    int   checks;
    int   passes;
    int   cnt;

    decade_step_monitor dut_a (
        .clk(clk), .reset(reset), .q_in(q_in), .clr(clr),
        .digit(digit_a), .locked(locked_a), .step_pulse(step_a),
        .carry_pulse(carry_a), .restart_pulse(restart_a),
        .decade_count(count_a), .err(err_a), .err_code(code_a)
    );

    decade_step_monitor #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .q_in(q_in), .clr(clr),
        .digit(digit_b), .locked(locked_b), .step_pulse(step_b),
        .carry_pulse(carry_b), .restart_pulse(restart_b),
        .decade_count(count_b), .err(err_b), .err_code(code_b)
    );

    assign obs_a = {digit_a, locked_a, step_a, carry_a, restart_a, count_a, count_b, err_a, code_a};
    assign obs_b = {digit_b, locked_b, step_b, carry_b, restart_b, count_a, count_b, err_b, code_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int d, input bit l, input bit s, input bit c,
                                input bit r, input int n, input bit er, input int code);
        exp_t x;
        x.digit   = 4'(d);
        x.locked  = l;
        x.step    = s;
        x.carry   = c;
        x.restart = r;
        x.c8      = 8'(n);
        x.c2      = 2'(n);
        x.err     = er;
        x.code    = 2'(code);
        return x;
    endfunction

    function automatic logic [9:0] hot(input int d);
        logic [9:0] v;
        v = 10'b1;
        return v << d;
    endfunction

    // Drive one sample, let the edge take it, settle just after the edge
    task automatic cycle(input logic [9:0] q, input logic c);
        q_in = q;
        clr  = c;
        @(posedge clk);
        #1;
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q_in  = 10'd0;
        clr   = 1'b0;
        #2 reset = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL reset_state: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        cnt = 0;
    endtask

    task automatic test_sync_lock();
        for (int i = 0; i < 4; i++) begin
            sb.push_back((i < 3) ? mk(0, 0, 0, 0, 0, 0, 0, 0) : mk(0, 1, 0, 0, 0, 0, 0, 0));
            cycle((i < 3) ? 10'h000 : 10'h001, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL sync_lock[%0d]: got %h / %h expected %h", i, obs_a, obs_b, e);
            else passes++;
        end
    endtask

    task automatic test_count_decade();
        int seq[$] = '{1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 9, 0};
        int prev;
        int steps;
        bit s, c;
        prev  = 0;
        steps = 0;
        foreach (seq[i]) begin
            s = (seq[i] != prev);
            c = (prev == 9) && (seq[i] == 0);
            if (c) cnt++;
            sb.push_back(mk(seq[i], 1, s, c, 0, cnt, 0, 0));
            cycle(hot(seq[i]), 1'b0);
            steps += int'(step_a);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL count_decade[%0d]: got %h / %h expected %h", i, obs_a, obs_b, e);
            else passes++;
            prev = seq[i];
        end
        checks++;
        if (steps !== 10) $display("FAIL step_total: got %0d expected 10", steps);
        else passes++;
    endtask

    task automatic test_wrap();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        cycle(10'h001, 1'b1);
        cnt = 0;
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL wrap_clr: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
        sb.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        cycle(10'h001, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL wrap_lock: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
        for (int dec = 0; dec < 5; dec++) begin
            for (int k = 1; k <= 10; k++) begin
                if (k == 10) cnt++;
                sb.push_back(mk(k % 10, 1, 1, k == 10, 0, cnt, 0, 0));
                cycle(hot(k % 10), 1'b0);
                e = sb.pop_front();
                if (k == 10 || dec == 0) begin
                    checks++;
                    if (obs_a !== e || obs_b !== e)
                        $display("FAIL wrap[%0d.%0d]: got %h / %h expected %h", dec, k, obs_a, obs_b, e);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_restart();
        for (int k = 1; k <= 6; k++) begin
            sb.push_back(mk(k, 1, 1, 0, 0, cnt, 0, 0));
            cycle(hot(k), 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL restart_climb[%0d]: got %h / %h expected %h", k, obs_a, obs_b, e);
            else passes++;
        end
        sb.push_back(mk(0, 1, 0, 0, 1, cnt, 0, 0));
        cycle(10'h001, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL restart: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
    endtask

    task automatic test_fault_skip();
        logic [9:0] q [7] = '{10'h002, 10'h004, 10'h008, 10'h040, 10'h000, 10'h008, 10'h000};
        logic       c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sb.push_back(mk(1, 1, 1, 0, 0, cnt, 0, 0));
        sb.push_back(mk(2, 1, 1, 0, 0, cnt, 0, 0));
        sb.push_back(mk(3, 1, 1, 0, 0, cnt, 0, 0));
        sb.push_back(mk(3, 0, 0, 0, 0, cnt, 1, 1));
        sb.push_back(mk(3, 0, 0, 0, 0, cnt, 1, 1));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(q[i], c[i]);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL fault_skip[%0d]: got %h / %h expected %h", i, obs_a, obs_b, e);
            else passes++;
        end
    endtask

    task automatic test_fault_zero_multi();
        logic [9:0] q [6] = '{10'h004, 10'h000, 10'h300, 10'h000, 10'h003, 10'h001};
        logic       c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        sb.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 1, 2));
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 1, 2));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            cycle(q[i], c[i]);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL fault_zero_multi[%0d]: got %h / %h expected %h", i, obs_a, obs_b, e);
            else passes++;
        end
    endtask

    task automatic test_clr_priority_and_async();
        logic [9:0] q [4] = '{10'h020, 10'h003, 10'h000, 10'h080};
        logic       c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        sb.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(7, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cycle(q[i], c[i]);
            e = sb.pop_front();
            checks++;
            if (obs_a !== e || obs_b !== e)
                $display("FAIL clr_priority[%0d]: got %h / %h expected %h", i, obs_a, obs_b, e);
            else passes++;
        end
        // Advance to a pulse-producing state, then pull reset between edges
        cycle(10'h100, 1'b0);
        #2 reset = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL async_reset: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk(4, 1, 0, 0, 0, 0, 0, 0));
        cycle(10'h010, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs_a !== e || obs_b !== e)
            $display("FAIL post_reset_sync: got %h / %h expected %h", obs_a, obs_b, e);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cnt    = 0;
        test_reset();
        test_sync_lock();
        test_count_decade();
        test_wrap();
        test_restart();
        test_fault_skip();
        test_fault_zero_multi();
        test_clr_priority_and_async();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
